// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//
// Bundles the instruction-fetch handshake and redirect signals between the
// fetch sequencer (slave side) and its environment: the instruction memory,
// the consumer of fetched instructions, and the redirect source (master side).
//
// Handshake: InstrValid/InstrReady follow strict valid/ready semantics. An
// instruction is accepted in exactly the cycles where InstrValid and
// InstrReady are both high at the rising clock edge. InstrValid never depends
// on InstrReady, and PC/InstrOut stay stable while InstrValid is high and
// InstrReady is low. The redirect fields (Branch, Zero, BranchOffset, Jump,
// JumpTarget) describe the instruction being accepted and are only looked at
// in an accept cycle.
//
// Signals:
//   Start        master->slave  leave IDLE, or restart from HALT
//   InstrIn      master->slave  instruction word at PC (combinational memory)
//   PC           slave->master  word address of the presented instruction
//   InstrOut     slave->master  InstrIn passed straight through
//   InstrValid   slave->master  an instruction is being presented
//   InstrReady   master->slave  consumer takes the presented instruction
//   Branch       master->slave  conditional redirect request
//   Zero         master->slave  condition for Branch
//   BranchOffset master->slave  signed word offset for Branch
//   Jump         master->slave  unconditional redirect request
//   JumpTarget   master->slave  jump word-target field
//   Halted       slave->master  sequencer stopped after the last address
//   FetchCount   slave->master  saturating count of accepted instructions
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              Start;
    logic [31:0]       InstrIn;
    logic [ADDR_W-1:0] PC;
    logic [31:0]       InstrOut;
    logic              InstrValid;
    logic              InstrReady;
    logic              Branch;
    logic              Zero;
    logic [15:0]       BranchOffset;
    logic              Jump;
    logic [25:0]       JumpTarget;
    logic              Halted;
    logic [15:0]       FetchCount;

    modport slave (
        input  Start, InstrIn, InstrReady, Branch, Zero, BranchOffset,
               Jump, JumpTarget,
        output PC, InstrOut, InstrValid, Halted, FetchCount
    );

    modport master (
        output Start, InstrIn, InstrReady, Branch, Zero, BranchOffset,
               Jump, JumpTarget,
        input  PC, InstrOut, InstrValid, Halted, FetchCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch sequencer with three phases: IDLE (after reset, waits for
// Start), RUN (presents PC/InstrOut and advances on every accept) and HALT
// (entered by the accept of the instruction at PC_LIMIT; Start restarts from
// RESET_PC with a cleared FetchCount).
//
// On an accept the next PC is, in priority order:
//   Jump        -> {upper ADDR_W-26 bits of PC+1, JumpTarget}
//   Branch&Zero -> PC + 1 + sign-extended BranchOffset
//   otherwise   -> PC + 1
// All PC arithmetic wraps modulo 2^ADDR_W.
//
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   Defined: a taken redirect is held pending, the following accept (the
//   delay slot) still steps to PC+1, and the pending target is loaded on the
//   accept of the delay-slot instruction. Redirect requests on the delay-slot
//   accept are ignored; a pending redirect is dropped when halting.
//   Undefined: redirects take effect on the very next cycle.
//
// Parameters:
//   ADDR_W   PC width in bits (8..32)
//   RESET_PC word address loaded on reset and on restart
//   PC_LIMIT word address of the last instruction fetched before halting
//
// Ports:
//   Clk       system clock, rising edge
//   Reset     synchronous, active-high reset
//   bus       fetch_sequencer_if slave modport (handshake + redirects)
//   dbg_state current FSM state, for observation only
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    fetch_sequencer_if.slave      bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LIMIT_ADDR = ADDR_W'(PC_LIMIT);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       count_q;

`ifdef FETCH_DELAY_SLOT_EN
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
`endif

    logic              accept;
    logic              at_limit;
    logic              redirect;
    logic [ADDR_W-1:0] pc_inc;
    logic [31:0]       pc_inc_w;
    logic [31:0]       jump_w;
    logic [31:0]       off_w;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] redirect_target;
    logic [15:0]       count_next;

    assign accept   = (state == S_RUN) && bus.InstrReady;
    assign at_limit = (pc_q == LIMIT_ADDR);
    assign pc_inc   = pc_q + ADDR_W'(1);

    // The jump keeps the region bits of PC+1 above bit 25. Working in a
    // 32-bit scratch value lets one expression cover every ADDR_W: for
    // ADDR_W <= 26 the region bits fall away in the final truncation.
    assign pc_inc_w = 32'(pc_inc);
    assign jump_w   = (pc_inc_w & 32'hFC00_0000) | {6'd0, bus.JumpTarget};
    assign jump_addr = ADDR_W'(jump_w);

    assign off_w       = {{16{bus.BranchOffset[15]}}, bus.BranchOffset};
    assign branch_addr = pc_inc + ADDR_W'(off_w);

    assign redirect        = bus.Jump || (bus.Branch && bus.Zero);
    assign redirect_target = bus.Jump ? jump_addr : branch_addr;

    assign count_next = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            pc_q    <= RESET_ADDR;
            count_q <= 16'd0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid  <= 1'b0;
            pend_target <= RESET_ADDR;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // Without an accept everything holds (stall).
                    if (accept) begin
                        count_q <= count_next;
                        if (at_limit) begin
                            // PC stays on the last address; any redirect on
                            // this accept, or still pending, is discarded.
                            state <= S_HALT;
`ifdef FETCH_DELAY_SLOT_EN
                            pend_valid <= 1'b0;
`endif
                        end else begin
`ifdef FETCH_DELAY_SLOT_EN
                            if (pend_valid) begin
                                // Delay-slot accept: jump to the stored
                                // target, ignoring new redirect requests.
                                pc_q       <= pend_target;
                                pend_valid <= 1'b0;
                            end else if (redirect) begin
                                pc_q        <= pc_inc;
                                pend_valid  <= 1'b1;
                                pend_target <= redirect_target;
                            end else begin
                                pc_q <= pc_inc;
                            end
`else
                            pc_q <= redirect ? redirect_target : pc_inc;
`endif
                        end
                    end
                end

                S_HALT: begin
                    if (bus.Start) begin
                        state   <= S_RUN;
                        pc_q    <= RESET_ADDR;
                        count_q <= 16'd0;
`ifdef FETCH_DELAY_SLOT_EN
                        pend_valid <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PC         = pc_q;
    assign bus.InstrOut   = bus.InstrIn;
    assign bus.InstrValid = (state == S_RUN);
    assign bus.Halted     = (state == S_HALT);
    assign bus.FetchCount = count_q;
    assign dbg_state      = state;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: PC width in bits; legal range 8..32.
REQ-002 Parameter RESET_PC, default 0: word address loaded into PC on Reset and on restart.
REQ-003 Parameter PC_LIMIT, default 5: word address of the last instruction fetched before halting.
REQ-004 Clk  in  1  system clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  leaves IDLE, or restarts from HALT.
REQ-007 InstrIn  in  32  instruction word at address PC, read combinationally from the instruction memory.
REQ-008 PC  out  ADDR_W  word address of the instruction being presented.
REQ-009 InstrOut  out  32  equals InstrIn, combinationally.
REQ-010 InstrValid  out  1  high in RUN only.
REQ-011 InstrReady  in  1  consumer accepts; accept = InstrValid & InstrReady.
REQ-012 Branch, Zero  in  1 each  conditional redirect request for the accepted instruction.
REQ-013 BranchOffset  in  16  signed word offset for the branch.
REQ-014 Jump  in  1  unconditional redirect request for the accepted instruction.
REQ-015 JumpTarget  in  26  jump word-target field.
REQ-016 Halted  out  1  high in HALT.
REQ-017 FetchCount  out  16  count of accepted instructions.

Function
REQ-018 States: IDLE, RUN, HALT; IDLE->RUN on Start; RUN->HALT on an accept while PC==PC_LIMIT; HALT->RUN on Start.
REQ-019 On a HALT->RUN restart, PC<=RESET_PC and FetchCount<=0.
REQ-020 Redirect inputs are sampled only in a cycle with an accept; otherwise they are ignored.
REQ-021 In RUN without an accept (stall), PC, state and counters hold.
REQ-022 Next PC on accept, in priority order: Jump -> {PC+1 upper ADDR_W-26 bits, JumpTarget} (truncated to ADDR_W when ADDR_W<=26); Branch&Zero -> PC+1+sext(BranchOffset); else PC+1.
REQ-023 All PC arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFF+1 wraps to 0 with no flag.
REQ-024 Branch with Zero low is sequential.
REQ-025 FetchCount increments on each accept and saturates at 0xFFFF.
REQ-026 The accept at PC_LIMIT is counted; PC then holds that address in HALT, and any redirect on that accept is discarded.
REQ-027 Start while in RUN is ignored.
REQ-028 Latency: a redirect on an accept in cycle n presents the target at PC in cycle n+1 (no bubble).

Reset
REQ-029 Reset has priority over all inputs: state<=IDLE, PC<=RESET_PC, FetchCount<=0, any pending redirect cleared.
REQ-030 During and after Reset until Start: InstrValid=0 and Halted=0.
REQ-031 Reset asserted in the middle of a stall or a delay slot aborts it with no residual state.

Configuration
REQ-032 Macro FETCH_DELAY_SLOT_EN.
REQ-033 When FETCH_DELAY_SLOT_EN is defined, a taken redirect is stored as pending, and the next accept is the delay slot: it fetches sequentially (PC+1), then PC<=pending target.
REQ-034 With FETCH_DELAY_SLOT_EN, redirect requests on the delay-slot accept are ignored; the pending redirect is dropped if the halt condition fires.
REQ-035 When FETCH_DELAY_SLOT_EN is undefined, redirects apply immediately per REQ-022 and no pending register exists.

Verification
REQ-036 Reset, Start, InstrReady=1 constantly, no redirects, PC_LIMIT=5 -> PC 0,1,2,3,4,5; Halted=1 next cycle; FetchCount=6; PC holds 5.
REQ-037 At PC=2, Branch=1, Zero=1, BranchOffset=0xFFFE with accept -> next PC=1; same with Zero=0 -> next PC=3.
REQ-038 At PC=1, Jump=1 and Branch=1/Zero=1 together, JumpTarget=4 -> next PC=4 (jump wins).
REQ-039 InstrReady=0 for 3 cycles at PC=3 with Branch=1/Zero=1 asserted -> PC stays 3, FetchCount unchanged; accept on the 4th cycle -> branch taken.
REQ-040 FETCH_DELAY_SLOT_EN defined, jump to 0 accepted at PC=1 -> PC sequence 1,2,0; a jump requested at PC=2 is ignored.
REQ-041 Reset pulsed at PC=3 with a redirect pending -> PC=RESET_PC, IDLE, FetchCount=0; after Start, fetch is sequential from 0.
